// File: rtl/fifo_in_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional packet lock (grant held until req_last) enabled by defining FIFO_ARB_LOCK_EN.
module fifo_in_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_vld,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_rdy,
  output logic [DATA_WIDTH-1:0]            data_in,
  output logic                             data_in_vld,
  input  logic                             data_in_rdy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] g;
  logic [ID_W-1:0] g_next;
  logic            space;
  logic            take;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic found;
    int unsigned idx;
    win   = rr_ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_vld[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] lock_id;

  assign g    = (state == ST_LOCKED) ? lock_id : win;
  assign busy = data_in_vld || (state == ST_LOCKED);
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign g           = win;
  assign busy        = data_in_vld;
`endif

  assign space  = !data_in_vld || data_in_rdy;
  assign take   = !rst && req_vld[g] && space;
  assign g_next = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

  always_comb begin
    req_rdy = '0;
    if (take) req_rdy[g] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_in     <= '0;
      data_in_vld <= 1'b0;
      rr_ptr      <= '0;
      grant_id    <= '0;
`ifdef FIFO_ARB_LOCK_EN
      state       <= ST_ARB;
      lock_id     <= '0;
`endif
    end else begin
      if (take) begin
        data_in     <= req_data[g*DATA_WIDTH +: DATA_WIDTH];
        data_in_vld <= 1'b1;
      end else if (data_in_rdy) begin
        data_in_vld <= 1'b0;
      end

      if (req_vld[g]) grant_id <= g;

`ifdef FIFO_ARB_LOCK_EN
      // rr_ptr only advances once a packet completes.
      if (take) begin
        if (state == ST_ARB) begin
          if (req_last[g]) begin
            rr_ptr <= g_next;
          end else begin
            state   <= ST_LOCKED;
            lock_id <= g;
          end
        end else if (req_last[g]) begin
          state  <= ST_ARB;
          rr_ptr <= g_next;
        end
      end
`else
      if (take) rr_ptr <= g_next;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_in_arb.sv
// Self-checking bench for fifo_in_arb: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fifo_in_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_vld;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   data_in;
  logic           data_in_vld;
  logic           data_in_rdy;
  logic [1:0]     grant_id;
  logic           busy;

  int tests = 0;
  int fails = 0;

  fifo_in_arb #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_vld     (req_vld),
    .req_last    (req_last),
    .req_rdy     (req_rdy),
    .data_in     (data_in),
    .data_in_vld (data_in_vld),
    .data_in_rdy (data_in_rdy),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_vld     = '0;
    req_last    = '1;
    req_data    = '0;
    data_in_rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    req_vld     = 4'b1111;
    req_last    = '1;
    req_data    = 32'h44332211;
    data_in_rdy = 1'b1;
    #1;
    tests++;
    if (req_rdy !== 4'b0000) begin
      fails++; $display("FAIL reset_rdy: got %b want 0000", req_rdy);
    end
    tick();
    tick();
    tests++;
    if (data_in_vld !== 1'b0 || data_in !== 8'h00) begin
      fails++; $display("FAIL reset_out: got vld=%b data=%h want 0/00", data_in_vld, data_in);
    end
    tests++;
    if (grant_id !== 2'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_state: got grant=%0d busy=%b want 0/0", grant_id, busy);
    end
    rst     = 1'b0;
    req_vld = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_vld = 4'b0001;
    set_data(0, 8'h11);
    #1;
    tests++;
    if (req_rdy !== 4'b0001) begin
      fails++; $display("FAIL single_rdy: got %b want 0001", req_rdy);
    end
    tick();
    req_vld = '0;
    tests++;
    if (data_in !== 8'h11 || data_in_vld !== 1'b1 || grant_id !== 2'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_out: got data=%h vld=%b grant=%0d busy=%b want 11/1/0/1",
               data_in, data_in_vld, grant_id, busy);
    end
    tick();
    tests++;
    if (data_in_vld !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_drain: got vld=%b busy=%b want 0/0", data_in_vld, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 8'(8'hA0 + i));
    req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] exp;
      exp = '0;
      exp[k % N] = 1'b1;
      #1;
      tests++;
      if (req_rdy !== exp) begin
        fails++; $display("FAIL rr_rdy[%0d]: got %b want %b", k, req_rdy, exp);
      end
      tick();
      tests++;
      if (data_in !== 8'(8'hA0 + k % N) || grant_id !== 2'(k % N) || data_in_vld !== 1'b1) begin
        fails++;
        $display("FAIL rr_beat[%0d]: got data=%h grant=%0d vld=%b want %h/%0d/1",
                 k, data_in, grant_id, data_in_vld, 8'(8'hA0 + k % N), k % N);
      end
    end
    req_vld = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(0, 8'h31);
    set_data(1, 8'h32);
    req_vld = 4'b0011;
    tick();
    set_data(0, 8'h41);
    data_in_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (req_rdy !== 4'b0000) begin
        fails++; $display("FAIL stall_rdy[%0d]: got %b want 0000", k, req_rdy);
      end
      tick();
      tests++;
      if (data_in !== 8'h31 || data_in_vld !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d]: got %h/%b want 31/1", k, data_in, data_in_vld);
      end
    end
    data_in_rdy = 1'b1;
    #1;
    tests++;
    if (req_rdy !== 4'b0010) begin
      fails++; $display("FAIL resume_rdy: got %b want 0010", req_rdy);
    end
    tick();
    tests++;
    if (data_in !== 8'h32 || data_in_vld !== 1'b1 || grant_id !== 2'd1) begin
      fails++;
      $display("FAIL resume_beat: got %h/%b/%0d want 32/1/1", data_in, data_in_vld, grant_id);
    end
    #1;
    tests++;
    if (req_rdy !== 4'b0001) begin
      fails++; $display("FAIL wrap_rdy: got %b want 0001", req_rdy);
    end
    tick();
    tests++;
    if (data_in !== 8'h41 || grant_id !== 2'd0) begin
      fails++; $display("FAIL wrap_beat: got %h/%0d want 41/0", data_in, grant_id);
    end
    req_vld = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pv;
    logic [W-1:0] pd [N];
    logic         m_vld;
    int           m_ptr;
    int           m_grant;
    int           w;
    logic         xfer;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] sb [$];
    do_reset();
    pv      = '0;
    m_vld   = 1'b0;
    m_ptr   = 0;
    m_grant = 0;
    for (int i = 0; i < N; i++) pd[i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(2) == 0) begin
          pv[i] = 1'b1;
          pd[i] = 8'($urandom);
        end
      end
      req_vld = pv;
      for (int i = 0; i < N; i++) set_data(i, pd[i]);
      req_last    = '1;
      data_in_rdy = ($urandom_range(3) != 0);
      #1;
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      xfer    = (w >= 0) && (!m_vld || data_in_rdy);
      exp_rdy = '0;
      if (xfer) exp_rdy[w] = 1'b1;
      tests++;
      if (req_rdy !== exp_rdy) begin
        fails++; $display("FAIL rand_rdy[%0d]: got %b want %b", c, req_rdy, exp_rdy);
      end
      tests++;
      if (data_in_vld !== m_vld) begin
        fails++; $display("FAIL rand_vld[%0d]: got %b want %b", c, data_in_vld, m_vld);
      end
      if (m_vld && data_in_rdy) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rand_sb[%0d]: got %h want none queued", c, data_in);
        end else begin
          if (data_in !== sb[0]) begin
            fails++; $display("FAIL rand_data[%0d]: got %h want %h", c, data_in, sb[0]);
          end
          void'(sb.pop_front());
        end
      end
      if (xfer) begin
        sb.push_back(pd[w]);
        m_vld = 1'b1;
        m_ptr = (w + 1) % N;
        pv[w] = 1'b0;
      end else if (data_in_rdy) begin
        m_vld = 1'b0;
      end
      if (w >= 0) m_grant = w;
      tick();
      tests++;
      if (grant_id !== 2'(m_grant) || busy !== m_vld) begin
        fails++;
        $display("FAIL rand_grant[%0d]: got grant=%0d busy=%b want %0d/%b",
                 c, grant_id, busy, m_grant, m_vld);
      end
    end
    req_vld     = '0;
    data_in_rdy = 1'b1;
    tick();
  endtask

`ifdef FIFO_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] exp_rdy [6];
    logic [W-1:0] exp_dat [6];
    logic [N-1:0] vld_seq [6];
    logic [W-1:0] d2_seq  [6];
    logic         l2_seq  [6];
    exp_rdy = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0010};
    exp_dat = '{8'h70, 8'h70, 8'h71, 8'h72, 8'h50, 8'h51};
    vld_seq = '{4'b0111, 4'b0011, 4'b0111, 4'b0111, 4'b0011, 4'b0010};
    d2_seq  = '{8'h70, 8'h70, 8'h71, 8'h72, 8'h72, 8'h72};
    l2_seq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    // Single-beat packet from producer 1 moves priority to producer 2.
    set_data(1, 8'h61);
    req_vld = 4'b0010;
    tick();
    set_data(0, 8'h50);
    set_data(1, 8'h51);
    for (int k = 0; k < 6; k++) begin
      req_vld     = vld_seq[k];
      req_last[2] = l2_seq[k];
      set_data(2, d2_seq[k]);
      #1;
      tests++;
      if (req_rdy !== exp_rdy[k]) begin
        fails++; $display("FAIL lock_rdy[%0d]: got %b want %b", k, req_rdy, exp_rdy[k]);
      end
      tick();
      if (k == 1) begin
        tests++;
        if (busy !== 1'b1 || data_in_vld !== 1'b0) begin
          fails++; $display("FAIL lock_idle: got busy=%b vld=%b want 1/0", busy, data_in_vld);
        end
      end else begin
        tests++;
        if (data_in !== exp_dat[k] || data_in_vld !== 1'b1) begin
          fails++;
          $display("FAIL lock_beat[%0d]: got %h/%b want %h/1", k, data_in, data_in_vld, exp_dat[k]);
        end
      end
    end
    req_vld  = '0;
    req_last = '1;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    set_data(2, 8'h7A);
    req_last = 4'b1011;
    req_vld  = 4'b0100;
    tick();
    rst      = 1'b1;
    req_vld  = 4'b0110;
    req_last = '1;
    set_data(1, 8'h1B);
    #1;
    tests++;
    if (req_rdy !== 4'b0000) begin
      fails++; $display("FAIL rstmid_rdy: got %b want 0000", req_rdy);
    end
    tick();
    rst = 1'b0;
    tests++;
    if (data_in_vld !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_state: got vld=%b grant=%0d busy=%b want 0/0/0",
               data_in_vld, grant_id, busy);
    end
    #1;
    tests++;
    if (req_rdy !== 4'b0010) begin
      fails++; $display("FAIL rstmid_next: got %b want 0010", req_rdy);
    end
    tick();
    tests++;
    if (data_in !== 8'h1B || grant_id !== 2'd1) begin
      fails++; $display("FAIL rstmid_beat: got %h/%0d want 1b/1", data_in, grant_id);
    end
    req_vld = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
`ifdef FIFO_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_in_arb.md
# fifo_in_arb

Round-robin arbiter that shares the single `fifo` write port (`data_in` / `data_in_vld` / `data_in_rdy`) among `NUM_REQ` producers.
- Sits directly in front of `fifo`; `fifo_out_if` is untouched.
- Each producer has its own valid/ready channel. Accepted beats are registered and presented to the FIFO one cycle later.
- Optional packet lock keeps a grant until the producer's last beat.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers, ≥2.
- `DATA_WIDTH`, 8: beat width; equals the `fifo` `data_in` width.
- `ID_W`, `$clog2(NUM_REQ)`: grant index width (localparam).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  producer beats; producer i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_vld`  in  `NUM_REQ`  per-producer valid.
- `req_last`  in  `NUM_REQ`  per-producer end-of-packet; used only when `FIFO_ARB_LOCK_EN` is defined.
- `req_rdy`  out  `NUM_REQ`  per-producer ready; at most one bit high.
- `data_in`  out  `DATA_WIDTH`  beat to `fifo.data_in`.
- `data_in_vld`  out  1  to `fifo.data_in_vld`.
- `data_in_rdy`  in  1  from `fifo.data_in_rdy`.
- `grant_id`  out  `ID_W`  index of the currently granted producer.
- `busy`  out  1  high while the output register holds a beat, or while in LOCKED.

## Operation
Output register:
- `data_in` / `data_in_vld` are register outputs.
- `space = !data_in_vld || data_in_rdy`.
- A held beat stays stable until `data_in_vld && data_in_rdy`.

Arbitration:
- `rr_ptr` (`ID_W` bits) holds priority.
- Winner `g` = first i with `req_vld[i]`, scanning `rr_ptr, rr_ptr+1, …` mod `NUM_REQ`.
- `grant_id = g`. If no request, `grant_id` holds its last value.
- `req_rdy[g] = req_vld[g] && space`; all other `req_rdy` bits are 0.
- Transfer on `req_vld[g] && req_rdy[g]`:
  - `data_in <= req_data[g]`, `data_in_vld <= 1`.
  - `rr_ptr <= (g+1) mod NUM_REQ` (unless LOCKED; see Configuration).
- If `data_in_rdy` is high and there is no transfer, `data_in_vld <= 0`.

Producer rules:
- `req_vld` must not depend on `req_rdy`.
- `req_data` / `req_last` must hold stable while `req_vld && !req_rdy`.
- A producer may withdraw `req_vld` only after a transfer.

FSM, states ARB and LOCKED:
- ARB: winner is chosen each cycle as above.
- LOCKED: only available with `FIFO_ARB_LOCK_EN`.

Reset (`rst` = 1 at a rising edge):
- `data_in_vld = 0`, `data_in = 0`, `rr_ptr = 0`, `grant_id = 0`, state ARB, `busy = 0`.
- `req_rdy = 0` while `rst` is high.
- A beat held in the output register is discarded.
- Reset mid-packet clears the lock.

## Timing
- Latency: a beat accepted in cycle N is on `data_in` with `data_in_vld = 1` in cycle N+1.
- Throughput: one beat per cycle while `data_in_rdy` stays high.
- `req_rdy` is combinational from `req_vld`, `data_in_vld`, `data_in_rdy` and state. There is no combinational path from `req_data` to the outputs.
- Simultaneous output drain and new accept in the same cycle: the register is reloaded and `data_in_vld` stays 1.
- FIFO full (`data_in_rdy = 0`) with the register occupied: all `req_rdy = 0`, and `rr_ptr` and FSM state are frozen.
- Wrap-around: winner `NUM_REQ-1` sets `rr_ptr` to 0.
- All `req_vld` low: no state change except the register drain.

## Configuration
`FIFO_ARB_LOCK_EN`

Defined:
- A transfer in ARB with `req_last[g] = 0` moves the FSM to LOCKED with `lock_id = g`. `rr_ptr` is not updated.
- In LOCKED, the winner is forced to `lock_id`. Other requesters get `req_rdy = 0` even if the locked producer is idle.
- A transfer with `req_last[lock_id] = 1` returns the FSM to ARB and sets `rr_ptr <= lock_id+1`.
- A single-beat packet (`last = 1` in ARB) stays in ARB.

Not defined:
- `req_last` is ignored, and no LOCKED state or `lock_id` logic is built.
- Rotation happens on every beat.

## Test plan
- After reset, `req_vld = 4'b0001` with data `0x11`, `data_in_rdy = 1` → `req_rdy[0]` is high the same cycle; next cycle `data_in = 0x11`, `data_in_vld = 1`, `grant_id = 0`.
- `req_vld = 4'b1111` held, `data_in_rdy = 1`, no lock → grants go 0,1,2,3,0 on consecutive cycles, with `data_in` beats matching in order.
- `data_in_rdy = 0` for 5 cycles with the register occupied → `data_in` stable, all `req_rdy = 0`, `rr_ptr` unchanged. When `data_in_rdy` rises, the drain and the next accept happen in the same cycle.
- `FIFO_ARB_LOCK_EN`: producer 2 sends 3 beats with `last` on the 3rd while producers 0 and 1 request → 2,2,2 are granted first, then 0, then 1.
- `rst` asserted while `data_in_vld = 1` in the middle of a locked packet → next cycle `data_in_vld = 0`, state ARB, `grant_id = 0`; the next grant goes to the lowest active index at or after 0.
